// File: rtl/count_up_stopwatch_pkg.sv
// Shared constants for the count-up stopwatch: FSM state encoding and BCD digit limits.
package count_up_stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] LIM_SEC_ONES = 4'd9;
  localparam logic [3:0] LIM_SEC_TENS = 4'd5;
  localparam logic [3:0] LIM_MIN_ONES = 4'd9;
  localparam int         MAX_MIN_TENS_DEF = 9;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/count_up_stopwatch_bcd_digit_ctr.sv
// One BCD digit of the stopwatch: wraps to zero past its limit, carry flags terminal count.
module bcd_digit_ctr
  import count_up_stopwatch_pkg::*;
(
  input  logic       uclock,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] limit,
  output logic [3:0] value,
  output logic       carry
);

  bcd_t incremented;

  // carry is a terminal-count flag; the parent ANDs it into the next digit's enable
  assign carry       = (value == limit);
  assign incremented = carry ? 4'd0 : value + 4'd1;

  always_ff @(posedge uclock) begin
    if (clear) begin
      value <= 4'd0;
    end else if (enable) begin
      value <= incremented;
    end
  end

endmodule

// File: rtl/count_up_stopwatch.sv
// Count-up stopwatch: button edge detect, run/pause/done FSM, lap freeze and
// a registered BCD display driven from a chain of digit counters.
module count_up_stopwatch #(
  parameter int MAX_MIN_TENS = count_up_stopwatch_pkg::MAX_MIN_TENS_DEF
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic       tick,
  input  logic       button2,
  input  logic       button3,
  input  logic       switch,
  input  logic       switch2,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic       running,
  output logic       lap,
  output logic       buzzer
);
  import count_up_stopwatch_pkg::*;

  localparam bcd_t LIM_MIN_TENS = 4'(MAX_MIN_TENS);

  logic [1:0] state, nextstate;
  logic       prev2, prev3;
  logic       mode, startedge, lapedge;
  logic       clrreq, clearcount, lapnext;
  logic       inc, atmax;
  logic       en1, en2, en3;
  logic       c0, c1, c2, c3;
  bcd_t       sec0, sec1, min0, min1;

  // A simultaneous start edge swallows the lap edge
  assign mode      = switch & ~switch2;
  assign startedge = mode & button2 & ~prev2;
  assign lapedge   = mode & button3 & ~prev3 & ~startedge;

  assign atmax = c0 & c1 & c2 & c3;
  assign inc   = (state == ST_RUN) & tick & ~atmax;
  assign en1   = inc & c0;
  assign en2   = en1 & c1;
  assign en3   = en2 & c2;

  // Reset shares the clear path so it always beats a same-cycle tick
  assign clearcount = reset | clrreq;

  bcd_digit_ctr u_sec0 (.uclock(uclock), .enable(inc), .clear(clearcount),
                        .limit(LIM_SEC_ONES), .value(sec0), .carry(c0));
  bcd_digit_ctr u_sec1 (.uclock(uclock), .enable(en1), .clear(clearcount),
                        .limit(LIM_SEC_TENS), .value(sec1), .carry(c1));
  bcd_digit_ctr u_min0 (.uclock(uclock), .enable(en2), .clear(clearcount),
                        .limit(LIM_MIN_ONES), .value(min0), .carry(c2));
  bcd_digit_ctr u_min1 (.uclock(uclock), .enable(en3), .clear(clearcount),
                        .limit(LIM_MIN_TENS), .value(min1), .carry(c3));

  // Saturation wins over a start edge arriving on the final tick
  always_comb begin
    nextstate = state;
    clrreq    = 1'b0;
    case (state)
      ST_IDLE:  if (startedge) nextstate = ST_RUN;
      ST_RUN: begin
        if (tick && atmax)  nextstate = ST_DONE;
        else if (startedge) nextstate = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (startedge) begin
          nextstate = ST_RUN;
        end else if (lapedge) begin
          nextstate = ST_IDLE;
          clrreq    = 1'b1;
        end
      end
      ST_DONE: begin
        if (lapedge) begin
          nextstate = ST_IDLE;
          clrreq    = 1'b1;
        end
      end
      default:  nextstate = ST_IDLE;
    endcase
    lapnext = (state == ST_RUN && nextstate == ST_RUN) ? (lap ^ lapedge) : 1'b0;
  end

  // Display freezes only while lap stays high; a rising lap captures this cycle's count
  always_ff @(posedge uclock) begin
    if (reset) begin
      state <= ST_IDLE;
      lap   <= 1'b0;
      prev2 <= button2;
      prev3 <= button3;
      num0  <= 4'd0;
      num1  <= 4'd0;
      num2  <= 4'd0;
      num3  <= 4'd0;
    end else begin
      state <= nextstate;
      lap   <= lapnext;
      prev2 <= button2;
      prev3 <= button3;
      if (!(lap && lapnext)) begin
        num0 <= sec0;
        num1 <= sec1;
        num2 <= min0;
        num3 <= min1;
      end
    end
  end

  assign running = (state == ST_RUN);
  assign buzzer  = (state == ST_DONE);

endmodule

// File: doc/count_up_stopwatch.md
COUNT_UP_STOPWATCH -- requirements
Module: count_up_stopwatch

Interface
REQ-001 SHALL have parameter MAX_MIN_TENS, default 9, the highest minutes-tens digit value before saturation.
REQ-002 SHALL have port uclock, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port tick, input, 1, a one-uclock-wide 1 Hz enable pulse synchronous to uclock.
REQ-005 SHALL have port button2, input, 1, the start/stop button, level, synchronous to uclock.
REQ-006 SHALL have port button3, input, 1, the lap/clear button, level, synchronous to uclock.
REQ-007 SHALL have ports switch and switch2, input, 1 each; stopwatch mode is selected when switch=1 and switch2=0.
REQ-008 SHALL have ports num0, num1, num2, num3, output, 4 each: seconds ones, seconds tens, minutes ones, minutes tens (BCD).
REQ-009 SHALL have port running, output, 1, high in state RUN.
REQ-010 SHALL have port lap, output, 1, high while the display is frozen.
REQ-011 SHALL have port buzzer, output, 1, high in state DONE.

Function
REQ-012 SHALL detect button rising edges internally (registered previous level); only edges act, and held levels are ignored.
REQ-013 SHALL ignore button edges when not in stopwatch mode; counting continues regardless of mode.
REQ-014 SHALL implement states IDLE (00:00, stopped), RUN, PAUSE, and DONE (saturated).
REQ-015 Transitions: IDLE + start edge -> RUN; RUN + start edge -> PAUSE; PAUSE + start edge -> RUN; PAUSE + lap edge -> IDLE with count cleared to 00:00; DONE + lap edge -> IDLE with count cleared; DONE ignores start edges.
REQ-016 In RUN, a lap edge SHALL toggle the lap flag; when lap rises, num0..num3 SHALL hold the count value of that cycle while the internal count continues.
REQ-017 When lap falls, or on any exit from RUN, the lap flag SHALL clear and the outputs SHALL track the live count on the next cycle.
REQ-018 The internal count SHALL advance by one second on each tick while the state register holds RUN in that cycle; a start edge in the same cycle does not suppress or create that increment.
REQ-019 Carry rules: sec-ones 9->0 carries; sec-tens 5->0 carries; min-ones 9->0 carries; min-tens increments up to MAX_MIN_TENS.
REQ-020 At MAX_MIN_TENS:9:5:9 (99:59 by default), the next tick SHALL NOT wrap; the count holds and the state becomes DONE on that same edge.
REQ-021 Simultaneous start and lap edges SHALL cause only the start edge to act; the lap edge is discarded.
REQ-022 Display outputs SHALL be registered, with one-cycle latency from count update to output.
REQ-023 All digits SHALL always be valid BCD within their range; no state reachable from reset yields a digit out of range.

Reset
REQ-024 While reset=1 at a uclock edge: state=IDLE, count=00:00, num0..num3=0, running=0, lap=0, buzzer=0, and edge-detect registers are loaded with the current button levels.
REQ-025 Reset mid-RUN or mid-lap SHALL abandon the count with no residual increment; reset SHALL override tick and button edges in the same cycle.

Structure
REQ-026 The shared package SHALL hold the state encoding constants and the digit limits (9, 5, MAX_MIN_TENS default).
REQ-027 One sub-module, bcd_digit_ctr, SHALL be instantiated per digit, with inputs for enable, limit, and clear, and outputs for value and carry; the top level holds the FSM, edge detect, lap latch, and saturation compare.

Verification
REQ-028 Reset, stopwatch mode, start edge, 75 ticks -> running=1, display 01:15.
REQ-029 At 00:10 in RUN, lap edge, 5 ticks -> display stays 00:10 with lap=1; second lap edge -> display 00:15 on the next cycle with lap=0.
REQ-030 At 00:20 in RUN, start edge, 3 ticks -> display stays 00:20 (PAUSE); lap edge -> IDLE, display 00:00.
REQ-031 Preload to 99:58 in RUN, 3 ticks -> display 99:59, buzzer=1, running=0; start edge -> no change; lap edge -> 00:00, buzzer=0.
REQ-032 Start and lap edges in the same cycle as a tick in RUN at 00:05 -> display 00:06, state PAUSE, lap=0.
REQ-033 switch2=1 with button edges -> state unchanged; reset asserted together with a tick in RUN -> all outputs 0 the next cycle.
